// File: rtl/mem8x8_ctrl_pkg.sv
// Shared definitions for the mem8x8 access controller: FSM states, default widths
// and a helper that sizes requester-index fields.
package mem8x8_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DEF_N_REQ      = 2;
   localparam int DEF_ADDR_W     = 3;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_STROBE_CYC = 1;

   // Index width that stays legal (>=1 bit) even for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem8x8_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches from (ptr+1) upward with wrap and
// returns the first active request as both a one-hot grant and a binary index.
module mem8x8_ctrl_rr_arbiter
   import mem8x8_ctrl_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int PW    = idx_w(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [PW-1:0]    idx_o,
   output logic             valid_o
);

   int cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/mem8x8_ctrl.sv
// Access controller for the mem8x8 bitcell array: round-robin arbitration and a
// registered SETUP -> STROBE -> HOLD sequence on one-hot row strobes.
module mem8x8_ctrl
   import mem8x8_ctrl_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STROBE_CYC = DEF_STROBE_CYC
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          wr,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic [DATA_W-1:0]         mem_inp,
   output logic [(1<<ADDR_W)-1:0]    mem_we,
   output logic [(1<<ADDR_W)-1:0]    mem_re,
   input  logic [DATA_W-1:0]         mem_outp
);

   localparam int ROWS  = 1 << ADDR_W;
   localparam int PW    = idx_w(N_REQ);
   localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

   state_t              state_q;
   logic [N_REQ-1:0]    gnt_q, ack_q;
   logic [DATA_W-1:0]   rdata_q, mem_inp_q, wdata_q;
   logic [ROWS-1:0]     mem_we_q, mem_re_q;
   logic                busy_q, wr_q;
   logic [PW-1:0]       ptr_q, owner_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [N_REQ-1:0]    arb_gnt;
   logic [PW-1:0]       arb_idx;
   logic                arb_valid;
   logic [ROWS-1:0]     row_sel;

   mem8x8_ctrl_rr_arbiter #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign row_sel = ROWS'(1) << addr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         mem_inp_q <= '0;
         mem_we_q  <= '0;
         mem_re_q  <= '0;
         busy_q    <= 1'b0;
         ptr_q     <= PW'(N_REQ - 1);
         owner_q   <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  // Requester inputs are captured here; later changes are ignored.
                  gnt_q     <= arb_gnt;
                  owner_q   <= arb_idx;
                  wr_q      <= wr[arb_idx];
                  addr_q    <= addr[arb_idx*ADDR_W +: ADDR_W];
                  wdata_q   <= wdata[arb_idx*DATA_W +: DATA_W];
                  mem_inp_q <= wr[arb_idx] ? wdata[arb_idx*DATA_W +: DATA_W] : '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               cnt_q    <= '0;
               mem_we_q <= wr_q ? row_sel : '0;
               mem_re_q <= wr_q ? '0 : row_sel;
               state_q  <= ST_STROBE;
            end
            ST_STROBE: begin
               if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
                  mem_we_q <= '0;
                  mem_re_q <= '0;
                  ack_q    <= gnt_q;
                  if (!wr_q) begin
                     rdata_q <= mem_outp;
                  end
                  state_q  <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_HOLD: begin
               gnt_q     <= '0;
               mem_inp_q <= '0;
               busy_q    <= 1'b0;
               ptr_q     <= owner_q;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign rdata   = rdata_q;
   assign busy    = busy_q;
   assign mem_inp = mem_inp_q;
   assign mem_we  = mem_we_q;
   assign mem_re  = mem_re_q;

   // wdata_q keeps the captured word for the whole transaction.
   logic unused_wdata;
   assign unused_wdata = ^wdata_q;

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Directed bench for mem8x8_ctrl: table of single transactions against a bitcell
// array model, plus reset-mid-strobe, all-rows and STROBE_CYC=3 timing sequences.
module tb_mem8x8_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: STROBE_CYC = 1, with array model
   logic [1:0]  req_a = '0, wr_a = '0, gnt_a, ack_a;
   logic [5:0]  addr_a = '0;
   logic [15:0] wdata_a = '0;
   logic [7:0]  rdata_a, mem_inp_a, mem_we_a, mem_re_a, mem_outp_a;
   logic        busy_a;

   mem8x8_ctrl #(.N_REQ(2), .ADDR_W(3), .DATA_W(8), .STROBE_CYC(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .wr(wr_a), .addr(addr_a),
      .wdata(wdata_a), .gnt(gnt_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a),
      .mem_inp(mem_inp_a), .mem_we(mem_we_a), .mem_re(mem_re_a), .mem_outp(mem_outp_a)
   );

   // Instance B: STROBE_CYC = 3, timing only
   logic [1:0]  req_b = '0, wr_b = '0, gnt_b, ack_b;
   logic [5:0]  addr_b = '0;
   logic [15:0] wdata_b = '0;
   logic [7:0]  rdata_b, mem_inp_b, mem_we_b, mem_re_b;
   logic [7:0]  mem_outp_b = '0;
   logic        busy_b;

   mem8x8_ctrl #(.N_REQ(2), .ADDR_W(3), .DATA_W(8), .STROBE_CYC(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .wr(wr_b), .addr(addr_b),
      .wdata(wdata_b), .gnt(gnt_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b),
      .mem_inp(mem_inp_b), .mem_we(mem_we_b), .mem_re(mem_re_b), .mem_outp(mem_outp_b)
   );

   // Bitcell array model: write on strobed edge, combinational read
   logic [7:0] arr [8];
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (mem_we_a[i]) arr[i] <= mem_inp_a;
      end
   end
   always_comb begin
      mem_outp_a = '0;
      for (int i = 0; i < 8; i++) begin
         if (mem_re_a[i]) mem_outp_a = mem_outp_a | arr[i];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         n_cmp++;
         if (!$onehot0(gnt_a) || !$onehot0(mem_we_a) || !$onehot0(mem_re_a) ||
             (mem_we_a != 0 && mem_re_a != 0)) begin
            n_bad++;
            $display("FAIL onehot_mon: gnt=%b we=%b re=%b expected one-hot-or-zero and exclusive",
                     gnt_a, mem_we_a, mem_re_a);
         end
      end
   end

   typedef struct {
      logic [1:0] req;
      logic [1:0] wr;
      logic [2:0] a0, a1;
      logic [7:0] d0, d1;
      logic [1:0] exp_gnt;
      logic       exp_we;
      logic [2:0] exp_row;
      logic [7:0] exp_inp;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   // Call at a negedge with DUT A idle; returns at the negedge after HOLD.
   task automatic run_vec(input vec_t v, input int n);
      logic [7:0] row;
      row = 8'd1 << v.exp_row;
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_gnt", 32'(gnt_a), 32'd0);
      req_a = v.req; wr_a = v.wr;
      addr_a = {v.a1, v.a0}; wdata_a = {v.d1, v.d0};
      @(negedge clk);
      chk("setup_gnt", 32'(gnt_a), 32'(v.exp_gnt));
      chk("setup_busy", 32'(busy_a), 32'd1);
      chk("setup_inp", 32'(mem_inp_a), 32'(v.exp_inp));
      chk("setup_strb", 32'({mem_we_a, mem_re_a}), 32'd0);
      @(negedge clk);
      chk("strobe_we", 32'(mem_we_a), v.exp_we ? 32'(row) : 32'd0);
      chk("strobe_re", 32'(mem_re_a), v.exp_we ? 32'd0 : 32'(row));
      chk("strobe_ack", 32'(ack_a), 32'd0);
      @(negedge clk);
      chk("hold_ack", 32'(ack_a), 32'(v.exp_gnt));
      chk("hold_strb", 32'({mem_we_a, mem_re_a}), 32'd0);
      chk("hold_inp", 32'(mem_inp_a), 32'(v.exp_inp));
      chk("hold_rdata", 32'(rdata_a), 32'(v.exp_rdata));
      $display("txn %0d: req=%b gnt=%b we=%b re=%b rdata=%h", n, v.req, gnt_a,
               v.exp_we, ~v.exp_we, rdata_a);
      @(negedge clk);
      chk("post_ack", 32'(ack_a), 32'd0);
      chk("post_inp", 32'(mem_inp_a), 32'd0);
   endtask

   initial begin
      int ack_at, we_cnt, bad;
      vec_t v;

      //         req    wr     a0    a1    d0     d1     gnt    we    row   inp    rdata
      vecs[0]  = '{2'b01, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 3'd5, 8'hA5, 8'h00};
      vecs[1]  = '{2'b01, 2'b00, 3'd5, 3'd0, 8'h00, 8'h00, 2'b01, 1'b0, 3'd5, 8'h00, 8'hA5};
      vecs[2]  = '{2'b10, 2'b10, 3'd0, 3'd2, 8'h00, 8'h5A, 2'b10, 1'b1, 3'd2, 8'h5A, 8'hA5};
      vecs[3]  = '{2'b11, 2'b11, 3'd1, 3'd3, 8'h11, 8'h33, 2'b01, 1'b1, 3'd1, 8'h11, 8'hA5};
      vecs[4]  = '{2'b11, 2'b11, 3'd1, 3'd3, 8'h11, 8'h33, 2'b10, 1'b1, 3'd3, 8'h33, 8'hA5};
      vecs[5]  = '{2'b11, 2'b11, 3'd1, 3'd3, 8'h11, 8'h33, 2'b01, 1'b1, 3'd1, 8'h11, 8'hA5};
      vecs[6]  = '{2'b11, 2'b11, 3'd1, 3'd3, 8'h11, 8'h33, 2'b10, 1'b1, 3'd3, 8'h33, 8'hA5};
      vecs[7]  = '{2'b10, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00, 2'b10, 1'b0, 3'd3, 8'h00, 8'h33};
      vecs[8]  = '{2'b01, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00, 2'b01, 1'b0, 3'd2, 8'h00, 8'h5A};
      vecs[9]  = '{2'b11, 2'b00, 3'd1, 3'd5, 8'h00, 8'h00, 2'b10, 1'b0, 3'd5, 8'h00, 8'hA5};
      vecs[10] = '{2'b11, 2'b00, 3'd1, 3'd5, 8'h00, 8'h00, 2'b01, 1'b0, 3'd1, 8'h00, 8'h11};

      // Power-on reset
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt_a), 32'd0);
      chk("rst_ack", 32'(ack_a), 32'd0);
      chk("rst_rdata", 32'(rdata_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_inp", 32'(mem_inp_a), 32'd0);
      chk("rst_strb", 32'({mem_we_a, mem_re_a}), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], i);
      end

      // Reset in the middle of STROBE: transaction dropped, rdata cleared
      req_a = 2'b01; wr_a = 2'b01; addr_a = {3'd0, 3'd7}; wdata_a = {8'h00, 8'hFF};
      @(negedge clk);
      @(negedge clk);
      chk("midrst_pre_we", 32'(mem_we_a), 32'h80);
      rst_n = 1'b0; req_a = 2'b00;
      @(negedge clk);
      chk("midrst_strb", 32'({mem_we_a, mem_re_a}), 32'd0);
      chk("midrst_gnt", 32'(gnt_a), 32'd0);
      chk("midrst_ack", 32'(ack_a), 32'd0);
      chk("midrst_rdata", 32'(rdata_a), 32'd0);
      chk("midrst_busy", 32'(busy_a), 32'd0);
      chk("midrst_inp", 32'(mem_inp_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack_a != 0 || busy_a != 0) bad++;
      end
      chk("midrst_no_ack", 32'(bad), 32'd0);

      // All rows: write i^3C, then read back
      for (int i = 0; i < 8; i++) begin
         v = '{2'b01, 2'b01, 3'(i), 3'd0, 8'(i) ^ 8'h3C, 8'h00, 2'b01, 1'b1, 3'(i),
               8'(i) ^ 8'h3C, 8'h00};
         run_vec(v, 11 + i);
      end
      for (int i = 0; i < 8; i++) begin
         v = '{2'b01, 2'b00, 3'(i), 3'd0, 8'h00, 8'h00, 2'b01, 1'b0, 3'(i),
               8'h00, 8'(i) ^ 8'h3C};
         run_vec(v, 19 + i);
      end
      req_a = 2'b00;

      // STROBE_CYC=3 timing; inputs altered right after the grant
      req_b = 2'b01; wr_b = 2'b01; addr_b = {3'd0, 3'd6}; wdata_b = {8'h00, 8'hC3};
      ack_at = 0; we_cnt = 0; bad = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            addr_b = {3'd0, 3'd1}; wdata_b = 16'h0000; wr_b = 2'b00;
         end
         if (mem_we_b == 8'b0100_0000) we_cnt++;
         else if (mem_we_b != 0) bad++;
         if (mem_re_b != 0) bad++;
         if (k <= 5 && (mem_inp_b !== 8'hC3 || gnt_b !== 2'b01)) bad++;
         if (k == 6 && (mem_inp_b !== 8'h00 || gnt_b !== 2'b00)) bad++;
         if (ack_b != 0 && ack_at == 0) begin
            ack_at = k;
            req_b = 2'b00;
         end else if (ack_b != 0) begin
            bad++;
         end
      end
      chk("b_ack_latency", 32'(ack_at), 32'd5);
      chk("b_strobe_cycles", 32'(we_cnt), 32'd3);
      chk("b_latched_inputs", 32'(bad), 32'd0);
      $display("txn 27: strobe_cyc=3 ack_at=%0d strobe_cycles=%0d", ack_at, we_cnt);

      mon_en = 1'b0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
